// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side bundle of the memory port arbiter.
// slave faces the arbiter, master faces the caches/memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_ic_req;
  logic [ADDR_W-1:0] i_ic_addr;
  logic              o_ic_beat;
  logic [DATA_W-1:0] o_ic_rdata;
  logic              o_ic_done;
  logic              i_dc_req;
  logic              i_dc_we;
  logic [ADDR_W-1:0] i_dc_addr;
  logic [DATA_W-1:0] i_dc_wdata;
  logic              o_dc_beat;
  logic [DATA_W-1:0] o_dc_rdata;
  logic              o_dc_done;
  logic              o_mem_ren;
  logic              o_mem_wen;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_ready;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_ic_req, i_ic_addr,
    output o_ic_beat, o_ic_rdata, o_ic_done,
    input  i_dc_req, i_dc_we, i_dc_addr, i_dc_wdata,
    output o_dc_beat, o_dc_rdata, o_dc_done,
    output o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata,
    input  i_mem_ready, i_mem_rdata
  );

  modport master (
    output i_ic_req, i_ic_addr,
    input  o_ic_beat, o_ic_rdata, o_ic_done,
    output i_dc_req, i_dc_we, i_dc_addr, i_dc_wdata,
    input  o_dc_beat, o_dc_rdata, o_dc_done,
    input  o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata,
    output i_mem_ready, i_mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port for I/D cache bursts.
// Owner gets a fixed-length burst of sequential word beats.
module mem_port_arbiter #(
  parameter int BURST_WORDS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input logic i_clk,
  input logic i_rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    OWN_IC,
    OWN_DC
  } state_t;

  state_t            state;
  logic [CW-1:0]     beat;
  logic [ADDR_W-1:0] base;
  logic              we_q;
  logic              last_dc;
  logic [DATA_W-1:0] ic_rd_q;
  logic [DATA_W-1:0] dc_rd_q;

  logic              own_ic;
  logic              own_dc;
  logic              last_beat;
  logic [ADDR_W-1:0] offset;

  assign own_ic    = (state == OWN_IC);
  assign own_dc    = (state == OWN_DC);
  assign last_beat = (beat == CW'(BURST_WORDS - 1));
  assign offset    = ADDR_W'({beat, 2'b00});

  assign bus.o_mem_ren   = own_ic | (own_dc & ~we_q);
  assign bus.o_mem_wen   = own_dc & we_q;
  assign bus.o_mem_addr  = (own_ic | own_dc) ? base + offset : '0;
  assign bus.o_mem_wdata = (own_dc & we_q) ? bus.i_dc_wdata : '0;

  assign bus.o_ic_beat = own_ic & bus.i_mem_ready;
  assign bus.o_ic_done = bus.o_ic_beat & last_beat;
  assign bus.o_dc_beat = own_dc & bus.i_mem_ready;
  assign bus.o_dc_done = bus.o_dc_beat & last_beat;

  // Read data is bypassed on the beat so it is valid with the pulse,
  // then held in the register until the next beat of that requester.
  assign bus.o_ic_rdata = bus.o_ic_beat ? bus.i_mem_rdata : ic_rd_q;
  assign bus.o_dc_rdata = (bus.o_dc_beat & ~we_q) ? bus.i_mem_rdata
                                                  : dc_rd_q;

  // Grant, beat counting and read-data capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      beat    <= '0;
      base    <= '0;
      we_q    <= 1'b0;
      last_dc <= 1'b0;
      ic_rd_q <= '0;
      dc_rd_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          beat <= '0;
          if (bus.i_dc_req && (!bus.i_ic_req || !last_dc)) begin
            state   <= OWN_DC;
            base    <= bus.i_dc_addr;
            we_q    <= bus.i_dc_we;
            last_dc <= 1'b1;
          end else if (bus.i_ic_req) begin
            state   <= OWN_IC;
            base    <= bus.i_ic_addr;
            we_q    <= 1'b0;
            last_dc <= 1'b0;
          end
        end
        OWN_IC: begin
          if (bus.i_mem_ready) begin
            ic_rd_q <= bus.i_mem_rdata;
            beat    <= last_beat ? '0 : beat + CW'(1);
            if (last_beat) state <= IDLE;
          end
        end
        OWN_DC: begin
          if (bus.i_mem_ready) begin
            if (!we_q) dc_rd_q <= bus.i_mem_rdata;
            beat <= last_beat ? '0 : beat + CW'(1);
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
